// File: rtl/hc_stream_responder.sv
`default_nettype none
// ============================================================================
// Module      : hc_stream_responder
// Description : Responder end of the buffer read-stream protocol. Accepts a
//               (buffer, line count) request and returns that many lines, in
//               order, from a local per-buffer line memory over a valid/ready
//               response channel with full backpressure. Line addresses wrap
//               modulo DEPTH, so streams longer than a buffer repeat it.
//               A separate preload port fills the line memory.
// Ports       : clk, reset (async, active-low)
//               req_valid/req_ready/req_buffer/req_size   - stream request
//               rsp_valid/rsp_ready/rsp_data/rsp_index/rsp_last - response
//               done                                       - completion pulse
//               mem_we/mem_buffer/mem_addr/mem_data        - preload write
// Revision    : 1.0 - initial release
// ============================================================================
module hc_stream_responder #(
    parameter  int NUM_BUFFERS = 4,
    parameter  int DEPTH       = 64,
    parameter  int LINE_WIDTH  = 512,
    parameter  int SIZE_WIDTH  = 16,
    localparam int BW          = $clog2(NUM_BUFFERS),
    localparam int AW          = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [BW-1:0]         req_buffer,
    input  logic [SIZE_WIDTH-1:0] req_size,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [LINE_WIDTH-1:0] rsp_data,
    output logic [SIZE_WIDTH-1:0] rsp_index,
    output logic                  rsp_last,
    output logic                  done,
    input  logic                  mem_we,
    input  logic [BW-1:0]         mem_buffer,
    input  logic [AW-1:0]         mem_addr,
    input  logic [LINE_WIDTH-1:0] mem_data
);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_STREAM = 2'd1;
    localparam logic [1:0] c_ST_FLUSH  = 2'd2;

    localparam logic [SIZE_WIDTH-1:0] c_ONE = SIZE_WIDTH'(1);

    // Line storage: one synchronous read port, one write port.
    logic [LINE_WIDTH-1:0] r_mem [NUM_BUFFERS*DEPTH];

    logic [1:0]            r_state;
    logic [BW-1:0]         r_buf;
    logic [SIZE_WIDTH-1:0] r_size;
    logic [SIZE_WIDTH-1:0] r_issue_cnt;
    logic [SIZE_WIDTH-1:0] r_ret_cnt;
    logic                  r_done;

    // Read pipeline stage: data captured from memory, pushed into the skid
    // FIFO on the following edge.
    logic                  r_rd_vld;
    logic [LINE_WIDTH-1:0] r_rd_data;

    // Two-entry skid FIFO feeding the response channel.
    logic [LINE_WIDTH-1:0] r_fifo_data [2];
    logic                  r_wptr;
    logic                  r_rptr;
    logic [1:0]            r_fifo_cnt;

    logic                  w_accept;
    logic                  w_pop;
    logic                  w_last_idx;
    logic                  w_issue;
    logic [2:0]            w_occ;
    logic [SIZE_WIDTH-1:0] w_size_m1;
    logic [BW+AW-1:0]      w_rd_addr;

    // req_ready is forced low for the whole time reset is held.
    assign req_ready  = reset && (r_state == c_ST_IDLE);
    assign w_accept   = req_valid && req_ready;

    assign rsp_valid  = (r_fifo_cnt != 2'd0);
    assign rsp_data   = r_fifo_data[r_rptr];
    assign rsp_index  = r_ret_cnt;
    assign w_size_m1  = r_size - c_ONE;
    assign w_last_idx = (r_ret_cnt == w_size_m1);
    assign rsp_last   = rsp_valid && w_last_idx;
    assign done       = r_done;

    assign w_pop      = rsp_valid && rsp_ready;

    // Lines already committed to the FIFO after this edge: current entries
    // minus the one leaving now, plus the read in flight. Issuing another read
    // is safe only if that leaves a slot for it two edges from now. Counting
    // the pop of this cycle is what lets a full-rate stream run bubble-free.
    assign w_occ      = {1'b0, r_fifo_cnt} + {2'b00, r_rd_vld} - {2'b00, w_pop};
    assign w_issue    = (r_state == c_ST_STREAM) && (r_issue_cnt != r_size) &&
                        (w_occ < 3'd2);
    assign w_rd_addr  = {r_buf, r_issue_cnt[AW-1:0]};

    // Memory: not reset. A same-cycle write and read of one address returns
    // the old contents because both are non-blocking updates of one edge.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            r_mem[{mem_buffer, mem_addr}] <= mem_data;
        end
        if (w_issue) begin
            r_rd_data <= r_mem[w_rd_addr];
        end
    end

    // Skid FIFO.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fifo_data[0] <= '0;
            r_fifo_data[1] <= '0;
            r_wptr         <= 1'b0;
            r_rptr         <= 1'b0;
            r_fifo_cnt     <= 2'd0;
        end else begin
            if (r_rd_vld) begin
                r_fifo_data[r_wptr] <= r_rd_data;
                r_wptr              <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            case ({r_rd_vld, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + 2'd1;
                2'b01:   r_fifo_cnt <= r_fifo_cnt - 2'd1;
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
        end
    end

    // Control FSM and counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= c_ST_IDLE;
            r_buf       <= '0;
            r_size      <= '0;
            r_issue_cnt <= '0;
            r_ret_cnt   <= '0;
            r_rd_vld    <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done   <= 1'b0;
            r_rd_vld <= w_issue;

            if (w_pop) begin
                r_ret_cnt <= r_ret_cnt + c_ONE;
            end
            if (w_issue) begin
                r_issue_cnt <= r_issue_cnt + c_ONE;
            end

            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        r_buf       <= req_buffer;
                        r_size      <= req_size;
                        r_issue_cnt <= '0;
                        r_ret_cnt   <= '0;
                        if (req_size != '0) begin
                            r_state <= c_ST_STREAM;
                        end else begin
                            // Empty stream: completes at once, no beats.
                            r_done <= 1'b1;
                        end
                    end
                end
                c_ST_STREAM: begin
                    if (w_issue && ((r_issue_cnt + c_ONE) == r_size)) begin
                        r_state <= c_ST_FLUSH;
                    end
                end
                c_ST_FLUSH: begin
                    if (w_pop && w_last_idx) begin
                        r_state <= c_ST_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
